// File: rtl/spike_scanner_if.sv
// Spike event stream between spike_scanner and the AER / spike-event output logic.
// The scanner is the master; the event consumer is the slave.
interface spike_scanner_if #(
    parameter int AW = 8
);
    logic          spike_valid;
    logic          spike_ready;
    logic [AW-1:0] spike_addr;
    logic          spike_pol;

    modport master (
        output spike_valid,
        input  spike_ready,
        output spike_addr,
        output spike_pol
    );

    modport slave (
        input  spike_valid,
        output spike_ready,
        input  spike_addr,
        input  spike_pol
    );
endinterface

// File: rtl/spike_scanner.sv
// spike_scanner: walks the charge accumulator one 32-bit word (4 signed 8-bit
// charges) per address, compares each charge against a signed threshold and
// emits one address event per firing neuron through a small output FIFO.
// Optional build macro SPIKE_SCANNER_NEG_EN: a lane also fires when
// charge <= -threshold, and such events carry spike_pol = 1.
module spike_scanner #(
    parameter int N          = 256,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                   CLK,
    input  logic                   RSTN,
    input  logic                   start_i,
    input  logic [7:0]             threshold_i,
    output logic [$clog2(N/4)-1:0] count_o,
    input  logic [31:0]            charge_word_i,
    output logic                   busy_o,
    output logic                   done_o,
    output logic [$clog2(N+1)-1:0] spike_count_o,
    spike_scanner_if.master        spike_if
);

    localparam int NW  = N / 4;
    localparam int CW  = $clog2(NW);
    localparam int AW  = $clog2(N);
    localparam int SCW = $clog2(N + 1);
    localparam int PW  = $clog2(FIFO_DEPTH);
    localparam int FW  = PW + 1;
`ifdef SPIKE_SCANNER_NEG_EN
    localparam int EW  = AW + 1;
`else
    localparam int EW  = AW;
`endif

    localparam logic [CW-1:0] LAST_WORD = CW'(NW - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_LOAD,
        S_EMIT,
        S_DRAIN
    } state_e;

    state_e           state_q, state_d;
    logic [CW-1:0]    count_q, count_d;
    logic [7:0]       thr_q, thr_d;
    logic [3:0]       mask_q, mask_d;
    logic [SCW-1:0]   spike_count_q, spike_count_d;

    logic [3:0]       fire_pos;
    logic [3:0]       fire;
    logic [1:0]       lane;
    logic [3:0]       lane_bit;
    logic [3:0]       mask_left;
    logic             push;
    logic             pop;
    logic [EW-1:0]    push_data;

    logic [EW-1:0]    fifo_mem [FIFO_DEPTH];
    logic [PW-1:0]    wr_ptr_q, rd_ptr_q;
    logic [FW-1:0]    fill_q;
    logic             fifo_empty;
    logic             fifo_full;
    logic [EW-1:0]    fifo_head;

`ifdef SPIKE_SCANNER_NEG_EN
    logic [3:0]       pol_q, pol_d;
    logic [3:0]       fire_neg;
    logic signed [8:0] neg_thr;

    // 9-bit negation so that a threshold of -128 maps to +128 without wrapping.
    assign neg_thr = -$signed({thr_q[7], thr_q});
`endif

    // Per-lane threshold compare on the word currently addressed.
    always_comb begin
        // NOTE: every combinational output gets a default before any branch; a
        // path that leaves one unassigned would infer a latch.
        fire_pos = '0;
`ifdef SPIKE_SCANNER_NEG_EN
        fire_neg = '0;
`endif
        for (int k = 0; k < 4; k++) begin
            if ($signed(charge_word_i[8*k +: 8]) >= $signed(thr_q)) begin
                fire_pos[k] = 1'b1;
            end
`ifdef SPIKE_SCANNER_NEG_EN
            else if ($signed({charge_word_i[8*k+7], charge_word_i[8*k +: 8]}) <= neg_thr) begin
                fire_neg[k] = 1'b1;
            end
`endif
        end
    end

`ifdef SPIKE_SCANNER_NEG_EN
    assign fire = fire_pos | fire_neg;
`else
    assign fire = fire_pos;
`endif

    // Lowest pending lane of the captured mask; events leave in ascending order.
    always_comb begin
        lane = 2'd0;
        for (int k = 3; k >= 0; k--) begin
            if (mask_q[k]) lane = 2'(k);
        end
    end

    assign lane_bit  = 4'b0001 << lane;
    assign mask_left = mask_q & ~lane_bit;

`ifdef SPIKE_SCANNER_NEG_EN
    assign push_data = {pol_q[lane], count_q, lane};
`else
    assign push_data = {count_q, lane};
`endif

    // Scan FSM: next state, next register values and the done pulse.
    always_comb begin
        state_d       = state_q;
        count_d       = count_q;
        thr_d         = thr_q;
        mask_d        = mask_q;
        spike_count_d = spike_count_q;
`ifdef SPIKE_SCANNER_NEG_EN
        pol_d         = pol_q;
`endif
        push          = 1'b0;
        done_o        = 1'b0;

        unique case (state_q)
            S_IDLE: begin
                if (start_i) begin
                    state_d       = S_LOAD;
                    thr_d         = threshold_i;
                    count_d       = '0;
                    spike_count_d = '0;
                end
            end
            S_LOAD: begin
                mask_d = fire;
`ifdef SPIKE_SCANNER_NEG_EN
                pol_d  = fire_neg;
`endif
                if (|fire) begin
                    state_d = S_EMIT;
                end else if (count_q == LAST_WORD) begin
                    state_d = S_DRAIN;
                end else begin
                    count_d = count_q + 1'b1;
                end
            end
            S_EMIT: begin
                // A full FIFO still accepts a push when its head leaves this cycle.
                if (!fifo_full || pop) begin
                    push          = 1'b1;
                    mask_d        = mask_left;
                    spike_count_d = spike_count_q + 1'b1;
                    if (mask_left == '0) begin
                        if (count_q == LAST_WORD) begin
                            state_d = S_DRAIN;
                        end else begin
                            state_d = S_LOAD;
                            count_d = count_q + 1'b1;
                        end
                    end
                end
            end
            S_DRAIN: begin
                // Done only once every event has been taken by the consumer.
                if (fifo_empty) begin
                    done_o  = 1'b1;
                    count_d = '0;
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Scan state registers.
    always_ff @(posedge CLK or negedge RSTN) begin
        // NOTE: clocked state uses non-blocking assignments so every register
        // samples pre-edge values regardless of statement order.
        if (!RSTN) begin
            state_q       <= S_IDLE;
            count_q       <= '0;
            thr_q         <= '0;
            mask_q        <= '0;
            spike_count_q <= '0;
`ifdef SPIKE_SCANNER_NEG_EN
            pol_q         <= '0;
`endif
        end else begin
            state_q       <= state_d;
            count_q       <= count_d;
            thr_q         <= thr_d;
            mask_q        <= mask_d;
            spike_count_q <= spike_count_d;
`ifdef SPIKE_SCANNER_NEG_EN
            pol_q         <= pol_d;
`endif
        end
    end

    assign fifo_empty = (fill_q == '0);
    assign fifo_full  = (fill_q == FW'(FIFO_DEPTH));
    assign fifo_head  = fifo_mem[rd_ptr_q];
    assign pop        = spike_if.spike_valid && spike_if.spike_ready;

    // FIFO pointers and occupancy.
    always_ff @(posedge CLK or negedge RSTN) begin
        if (!RSTN) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            fill_q   <= '0;
        end else begin
            if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
            unique case ({push, pop})
                2'b10:   fill_q <= fill_q + 1'b1;
                2'b01:   fill_q <= fill_q - 1'b1;
                default: fill_q <= fill_q;
            endcase
        end
    end

    // FIFO storage write port.
    always_ff @(posedge CLK) begin
        // NOTE: storage is deliberately not reset; validity comes from the
        // reset pointers, and the head is masked to zero while the FIFO is empty.
        if (push) fifo_mem[wr_ptr_q] <= push_data;
    end

    assign spike_if.spike_valid = !fifo_empty;
    assign spike_if.spike_addr  = fifo_empty ? '0 : fifo_head[AW-1:0];
`ifdef SPIKE_SCANNER_NEG_EN
    assign spike_if.spike_pol   = fifo_empty ? 1'b0 : fifo_head[AW];
`else
    assign spike_if.spike_pol   = 1'b0;
`endif

    assign count_o       = count_q;
    assign busy_o        = (state_q != S_IDLE) || !fifo_empty;
    assign spike_count_o = spike_count_q;

endmodule

// File: tb/tb_spike_scanner.sv
// Directed testbench for spike_scanner. Inputs are driven 1 ns after the rising
// edge, outputs and stream handshakes are sampled on the falling edge.
module tb_spike_scanner;

    localparam int N  = 256;
    localparam int NW = N / 4;

    logic        CLK = 1'b0;
    logic        RSTN;
    logic        start;
    logic [7:0]  thr;
    logic [5:0]  count;
    logic [31:0] charge_word;
    logic        busy;
    logic        done;
    logic [8:0]  spike_count;

    logic [31:0] mem [NW];
    logic [8:0]  ev_q [$];

    int n_checks = 0;
    int n_errors = 0;

    spike_scanner_if #(.AW(8)) sif ();

    spike_scanner #(.N(N), .FIFO_DEPTH(4)) dut (
        .CLK           (CLK),
        .RSTN          (RSTN),
        .start_i       (start),
        .threshold_i   (thr),
        .count_o       (count),
        .charge_word_i (charge_word),
        .busy_o        (busy),
        .done_o        (done),
        .spike_count_o (spike_count),
        .spike_if      (sif.master)
    );

    // Accumulator model: word read combinationally from the scanner's address.
    assign charge_word = mem[count];

    always #5 CLK = ~CLK;

    // Record every accepted event as {pol, addr}.
    always @(negedge CLK) begin
        if (RSTN && sif.spike_valid && sif.spike_ready)
            ev_q.push_back({sif.spike_pol, sif.spike_addr});
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge CLK);
            #1;
        end
    endtask

    task automatic clear_mem();
        foreach (mem[i]) mem[i] = '0;
    endtask

    task automatic start_scan(input logic [7:0] t);
        ev_q.delete();
        thr   = t;
        start = 1'b1;
        tick(1);
        start = 1'b0;
    endtask

    // Counts falling edges from the accepted start until done_o; optionally
    // raises start_i during the done cycle. Returns the event count at done.
    task automatic wait_done(input string tag, input int budget, input bit poke_start,
                             output int cycles, output int n_ev);
        logic seen;
        seen   = 1'b0;
        cycles = 0;
        n_ev   = 0;
        while (!seen && cycles < budget) begin
            @(negedge CLK);
            cycles++;
            if (done) seen = 1'b1;
        end
        n_ev = ev_q.size();
        check({tag, "_done_seen"}, 32'(seen), 32'd1);
        if (poke_start) start = 1'b1;
        tick(1);
        start = 1'b0;
    endtask

    initial begin
        int cyc;
        int nev;
        int bad;
        logic found;
        logic [8:0] exp_ev;

        RSTN = 1'b0;
        start = 1'b0;
        thr = '0;
        sif.spike_ready = 1'b0;
        clear_mem();
        tick(2);

        // Reset values.
        check("rst_count",      32'(count),           32'd0);
        check("rst_busy",       32'(busy),            32'd0);
        check("rst_done",       32'(done),            32'd0);
        check("rst_valid",      32'(sif.spike_valid), 32'd0);
        check("rst_addr",       32'(sif.spike_addr),  32'd0);
        check("rst_pol",        32'(sif.spike_pol),   32'd0);
        check("rst_spike_cnt",  32'(spike_count),     32'd0);
        RSTN = 1'b1;
        tick(2);

        // Empty scan: N/4 LOAD cycles plus the done cycle; start in the done cycle is ignored.
        sif.spike_ready = 1'b1;
        start_scan(8'h01);
        wait_done("empty", 200, 1'b1, cyc, nev);
        check("empty_latency",      32'(cyc),         32'd65);
        check("empty_spike_cnt",    32'(spike_count), 32'd0);
        check("empty_events",       32'(ev_q.size()), 32'd0);
        check("start_in_done_busy", 32'(busy),        32'd0);
        check("start_in_done_cnt",  32'(count),       32'd0);

        // Single word: bytes 0x0A,0x10,0x00,0x7F at neurons 20..23, thr 0x10 -> 21, 23.
        clear_mem();
        mem[5] = 32'h7F00100A;
        start_scan(8'h10);
        wait_done("word5", 300, 1'b0, cyc, nev);
        check("word5_n_events", 32'(ev_q.size()), 32'd2);
        check("word5_ev0",      32'(ev_q[0]),     32'd21);
        check("word5_ev1",      32'(ev_q[1]),     32'd23);
        tick(5);
        check("word5_cnt_held", 32'(spike_count), 32'd2);

        // Back-pressure: all neurons fire, consumer stalled. Word 0's four
        // events fill the FIFO, word 1 is loaded and its first push stalls.
        foreach (mem[i]) mem[i] = 32'h20202020;
        sif.spike_ready = 1'b0;
        start_scan(8'h20);
        tick(100);
        check("stall_spike_cnt", 32'(spike_count),     32'd4);
        check("stall_count",     32'(count),           32'd1);
        check("stall_valid",     32'(sif.spike_valid), 32'd1);
        check("stall_head",      32'(sif.spike_addr),  32'd0);
        check("stall_busy",      32'(busy),            32'd1);
        sif.spike_ready = 1'b1;
        wait_done("stall", 2000, 1'b0, cyc, nev);
        check("stall_n_events",    32'(ev_q.size()), 32'd256);
        check("stall_ev_at_done",  32'(nev),         32'd256);
        check("stall_final_cnt",   32'(spike_count), 32'd256);
        bad = 0;
        foreach (ev_q[i]) if (ev_q[i] !== 9'(i)) bad++;
        check("stall_order_errs",  32'(bad),         32'd0);

        // Negative threshold: 0x80 (-128) at neuron 7 is below -1.
        clear_mem();
        mem[1] = 32'h80000000;
        start_scan(8'hFF);
        wait_done("neg_thr", 2000, 1'b0, cyc, nev);
        bad = 0;
`ifdef SPIKE_SCANNER_NEG_EN
        // -128 <= -(-1) = +1, so neuron 7 fires as a negative event.
        check("neg_thr_cnt",      32'(spike_count), 32'd256);
        check("neg_thr_n_events", 32'(ev_q.size()), 32'd256);
        foreach (ev_q[i]) begin
            exp_ev = (i == 7) ? 9'h107 : 9'(i);
            if (ev_q[i] !== exp_ev) bad++;
        end
`else
        check("neg_thr_cnt",      32'(spike_count), 32'd255);
        check("neg_thr_n_events", 32'(ev_q.size()), 32'd255);
        foreach (ev_q[i]) begin
            exp_ev = (i < 7) ? 9'(i) : 9'(i + 1);
            if (ev_q[i] !== exp_ev) bad++;
        end
`endif
        check("neg_thr_order_errs", 32'(bad), 32'd0);

        // Polarity: neuron 3 = -16, neuron 4 = +16, thr 0x10.
        clear_mem();
        mem[0] = 32'hF0000000;
        mem[1] = 32'h00000010;
        start_scan(8'h10);
        wait_done("pol", 300, 1'b0, cyc, nev);
`ifdef SPIKE_SCANNER_NEG_EN
        check("pol_n_events", 32'(ev_q.size()), 32'd2);
        check("pol_ev0",      32'(ev_q[0]),     32'h103);
        check("pol_ev1",      32'(ev_q[1]),     32'h004);
`else
        check("pol_n_events", 32'(ev_q.size()), 32'd1);
        check("pol_ev0",      32'(ev_q[0]),     32'h004);
`endif

        // Reset in the middle of word 10's EMIT with events queued in the FIFO.
        clear_mem();
        mem[10] = 32'h20202020;
        sif.spike_ready = 1'b0;
        start_scan(8'h20);
        found = 1'b0;
        for (int i = 0; i < 100 && !found; i++) begin
            @(negedge CLK);
            if (count == 6'd10) found = 1'b1;
        end
        check("rst_mid_reached_w10", 32'(found), 32'd1);
        @(negedge CLK);
        @(negedge CLK);
        check("rst_mid_pre_valid", 32'(sif.spike_valid), 32'd1);
        RSTN = 1'b0;
        #1;
        check("rst_mid_count",     32'(count),           32'd0);
        check("rst_mid_busy",      32'(busy),            32'd0);
        check("rst_mid_done",      32'(done),            32'd0);
        check("rst_mid_valid",     32'(sif.spike_valid), 32'd0);
        check("rst_mid_addr",      32'(sif.spike_addr),  32'd0);
        check("rst_mid_pol",       32'(sif.spike_pol),   32'd0);
        check("rst_mid_spike_cnt", 32'(spike_count),     32'd0);
        tick(2);
        RSTN = 1'b1;
        tick(1);

        // Rescan after reset starts from word 0 with no stale events.
        clear_mem();
        mem[0] = 32'h00000020;
        sif.spike_ready = 1'b1;
        start_scan(8'h20);
        wait_done("rescan", 300, 1'b0, cyc, nev);
        check("rescan_n_events", 32'(ev_q.size()), 32'd1);
        check("rescan_ev0",      32'(ev_q[0]),     32'd0);
        check("rescan_cnt",      32'(spike_count), 32'd1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
